m_mem_arbiter: RTL and testbench
================================

// Module: m_mem_arbiter
// PURPOSE: 2-master arbiter, downstream of m_mmu_sv32. Merges MMU page-table-walk/PTE-update traffic (ptw port) with CPU-side cache traffic (cpu port) onto one memory/interconnect port.
//   One transaction is outstanding at a time. Grant and response steering are registered.
// PARAMETERS:
//   W_ADDR  32  address width of all ports
//   W_DATA  32  data width of all ports
// PORTS:
//   CLK                clock, all state on rising edge
//   RST_X              in   1       async active-low reset, one clock domain
//   w_ptw_req          in   1       PTW request; level, held until w_ptw_resp
//   w_ptw_addr         in   W_ADDR  PTW physical address
//   w_ptw_we           in   1       PTW write (PTE A/D update), else read
//   w_ptw_wdata        in   W_DATA  PTW write data
//   w_ptw_resp         out  1       1-cycle pulse: PTW transaction done
//   w_cpu_req          in   1       cache-side request; level, held until w_cpu_resp
//   w_cpu_addr         in   W_ADDR  cache-side physical address
//   w_cpu_we           in   1       cache-side write, else read
//   w_cpu_wdata        in   W_DATA  cache-side write data
//   w_cpu_resp         out  1       1-cycle pulse: cache-side transaction done
//   w_rdata            out  W_DATA  read data, shared; valid only while a *_resp is high
//   w_mem_req          out  1       request to memory; level, held until w_mem_resp
//   w_mem_addr         out  W_ADDR  registered address of granted master
//   w_mem_we           out  1       registered write enable of granted master
//   w_mem_wdata        out  W_DATA  registered write data of granted master
//   w_mem_resp         in   1       1-cycle pulse from memory: transaction done
//   w_mem_rdata        in   W_DATA  memory read data, valid with w_mem_resp
// BEHAVIOUR:
// - FSM states: IDLE -> ISSUE -> RESP -> IDLE. Reset state is IDLE.
//   On reset, all outputs are 0 and the grant register is 0.
// - IDLE:
//   - If any req is high: latch the grant, then latch addr/we/wdata of the granted master. Next state is ISSUE.
//   - If no req is high: stay in IDLE.
// - ISSUE:
//   - w_mem_req=1; addr/we/wdata are driven from the latched registers and are stable for the whole state.
//   - On w_mem_resp: latch w_mem_rdata into w_rdata. Next state is RESP.
//   - Wait time in ISSUE is unbounded.
// - RESP:
//   - Exactly one resp output is high: the one for the granted master. w_mem_req=0.
//   - Next state is IDLE unconditionally.
// - Master rule: deassert req no later than the cycle after its resp. Re-arbitration in IDLE then never re-grants a finished request.
// - Minimum latency: req seen in cycle 0, w_mem_req in cycle 1. With a zero-wait w_mem_resp in cycle 1, the master resp is in cycle 2.
//   Back-to-back grants are 3 cycles apart.
// - Simultaneous reqs in IDLE: resolved by the policy in CONFIGURATION. The loser's req is held and is served in a later IDLE.
// - A master's req changing while the other master is granted has no effect on the transaction in flight.
// - w_mem_resp outside ISSUE is ignored.
// - Async reset mid-transaction: FSM returns to IDLE and all outputs drop to 0 immediately.
//   The lost transaction is not replayed; the masters reset too.
// - w_rdata holds its last value outside RESP, for both reads and writes.
// CONFIGURATION:
// - Macro ARB_RR_EN defined: round-robin. A 1-bit last-grant register (reset 0 = ptw) sets the order: on a tie, the master not granted last wins.
// - Macro ARB_RR_EN undefined: fixed priority, ptw > cpu. The last-grant register is not built. This guarantees forward progress of a page walk.
// TESTING:
// - ptw read addr=0x8000_1000; mem returns 0x2000_0401 after 3 cycles -> w_mem_addr=0x8000_1000, we=0; w_ptw_resp 1 cycle; w_rdata=0x2000_0401; w_cpu_resp stays 0.
// - cpu write addr=0x8000_0010 data=0xDEAD_BEEF; zero-wait mem -> w_mem_req in cycle 1, we=1, wdata=0xDEAD_BEEF; w_cpu_resp in cycle 2.
// - Both reqs held continuously, 4 txns -> fixed priority: ptw,ptw,ptw,ptw. With ARB_RR_EN: ptw,cpu,ptw,cpu.
// - cpu req asserted while ptw is in ISSUE -> w_mem_addr unchanged until w_ptw_resp; cpu is granted in the next IDLE.
// - RST_X low while in ISSUE -> w_mem_req=0 immediately. A w_mem_resp after release is ignored; no *_resp pulse is generated.
// - Spurious w_mem_resp in IDLE -> no *_resp pulse and w_rdata unchanged.

Source files
------------

// File: rtl/m_mem_arbiter.sv
// Two-master memory arbiter: merges MMU walk traffic and cache traffic onto one port.
// Define ARB_RR_EN for round-robin on ties; otherwise fixed priority with ptw first.
module m_mem_arbiter #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              w_ptw_req,
  input  logic [W_ADDR-1:0] w_ptw_addr,
  input  logic              w_ptw_we,
  input  logic [W_DATA-1:0] w_ptw_wdata,
  output logic              w_ptw_resp,
  input  logic              w_cpu_req,
  input  logic [W_ADDR-1:0] w_cpu_addr,
  input  logic              w_cpu_we,
  input  logic [W_DATA-1:0] w_cpu_wdata,
  output logic              w_cpu_resp,
  output logic [W_DATA-1:0] w_rdata,
  output logic              w_mem_req,
  output logic [W_ADDR-1:0] w_mem_addr,
  output logic              w_mem_we,
  output logic [W_DATA-1:0] w_mem_wdata,
  input  logic              w_mem_resp,
  input  logic [W_DATA-1:0] w_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [W_DATA-1:0] wdata_q, wdata_d;
  logic [W_DATA-1:0] rdata_q, rdata_d;
  logic              any_req;
  logic              pick;

  assign any_req = w_ptw_req | w_cpu_req;

  // pick: 0 selects ptw, 1 selects cpu
`ifdef ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      w_ptw_req & w_cpu_req: pick = ~last_q;
      w_cpu_req:             pick = 1'b1;
      default:               pick = 1'b0;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req)
      last_d = pick;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) last_q <= 1'b0;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    pick = ~w_ptw_req & w_cpu_req;
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          addr_d  = pick ? w_cpu_addr  : w_ptw_addr;
          we_d    = pick ? w_cpu_we    : w_ptw_we;
          wdata_d = pick ? w_cpu_wdata : w_ptw_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (w_mem_resp) begin
          rdata_d = w_mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign w_mem_req   = (state_q == ISSUE);
  assign w_mem_addr  = addr_q;
  assign w_mem_we    = we_q;
  assign w_mem_wdata = wdata_q;
  assign w_rdata     = rdata_q;
  assign w_ptw_resp  = (state_q == RESP) & ~gnt_q;
  assign w_cpu_resp  = (state_q == RESP) &  gnt_q;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter: reads, writes, ties, mid-flight
// requests, spurious responses and async reset.
module tb_m_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        w_ptw_req, w_ptw_we, w_ptw_resp;
  logic [31:0] w_ptw_addr, w_ptw_wdata;
  logic        w_cpu_req, w_cpu_we, w_cpu_resp;
  logic [31:0] w_cpu_addr, w_cpu_wdata;
  logic [31:0] w_rdata;
  logic        w_mem_req, w_mem_we, w_mem_resp;
  logic [31:0] w_mem_addr, w_mem_wdata, w_mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  m_mem_arbiter #(.W_ADDR(32), .W_DATA(32)) dut (
    .CLK        (CLK),
    .RST_X      (RST_X),
    .w_ptw_req  (w_ptw_req),
    .w_ptw_addr (w_ptw_addr),
    .w_ptw_we   (w_ptw_we),
    .w_ptw_wdata(w_ptw_wdata),
    .w_ptw_resp (w_ptw_resp),
    .w_cpu_req  (w_cpu_req),
    .w_cpu_addr (w_cpu_addr),
    .w_cpu_we   (w_cpu_we),
    .w_cpu_wdata(w_cpu_wdata),
    .w_cpu_resp (w_cpu_resp),
    .w_rdata    (w_rdata),
    .w_mem_req  (w_mem_req),
    .w_mem_addr (w_mem_addr),
    .w_mem_we   (w_mem_we),
    .w_mem_wdata(w_mem_wdata),
    .w_mem_resp (w_mem_resp),
    .w_mem_rdata(w_mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  logic exp_cpu [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST_X       = 1'b0;
    w_ptw_req   = 1'b0;
    w_ptw_addr  = '0;
    w_ptw_we    = 1'b0;
    w_ptw_wdata = '0;
    w_cpu_req   = 1'b0;
    w_cpu_addr  = '0;
    w_cpu_we    = 1'b0;
    w_cpu_wdata = '0;
    w_mem_resp  = 1'b0;
    w_mem_rdata = '0;
    repeat (2) step();
    chk("rst_mem_req", w_mem_req, 0);
    chk("rst_ptw_resp", w_ptw_resp, 0);
    chk("rst_cpu_resp", w_cpu_resp, 0);
    chk("rst_rdata", w_rdata, 0);
    chk("rst_addr", w_mem_addr, 0);
    chk("rst_we", w_mem_we, 0);
    chk("rst_wdata", w_mem_wdata, 0);
    RST_X = 1'b1;
    step();

    // ptw read, memory answers in the third ISSUE cycle
    w_ptw_req  = 1'b1;
    w_ptw_addr = 32'h8000_1000;
    w_ptw_we   = 1'b0;
    step();
    chk("t1_req", w_mem_req, 1);
    chk("t1_addr", w_mem_addr, 32'h8000_1000);
    chk("t1_we", w_mem_we, 0);
    step();
    chk("t1_wait_req", w_mem_req, 1);
    chk("t1_wait_presp", w_ptw_resp, 0);
    step();
    w_mem_resp  = 1'b1;
    w_mem_rdata = 32'h2000_0401;
    step();
    w_mem_resp  = 1'b0;
    w_mem_rdata = '0;
    chk("t1_presp", w_ptw_resp, 1);
    chk("t1_cresp", w_cpu_resp, 0);
    chk("t1_rdata", w_rdata, 32'h2000_0401);
    chk("t1_resp_req", w_mem_req, 0);
    w_ptw_req = 1'b0;
    step();
    chk("t1_presp_end", w_ptw_resp, 0);
    chk("t1_idle_req", w_mem_req, 0);
    chk("t1_rdata_hold", w_rdata, 32'h2000_0401);

    // cpu write, zero-wait memory
    w_cpu_req   = 1'b1;
    w_cpu_addr  = 32'h8000_0010;
    w_cpu_we    = 1'b1;
    w_cpu_wdata = 32'hDEAD_BEEF;
    step();
    chk("t2_req", w_mem_req, 1);
    chk("t2_addr", w_mem_addr, 32'h8000_0010);
    chk("t2_we", w_mem_we, 1);
    chk("t2_wdata", w_mem_wdata, 32'hDEAD_BEEF);
    w_mem_resp = 1'b1;
    step();
    w_mem_resp = 1'b0;
    chk("t2_cresp", w_cpu_resp, 1);
    chk("t2_presp", w_ptw_resp, 0);
    w_cpu_req = 1'b0;
    w_cpu_we  = 1'b0;
    step();
    chk("t2_cresp_end", w_cpu_resp, 0);

    // both held; last grant was cpu
`ifdef ARB_RR_EN
    exp_cpu = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_cpu = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    w_ptw_req  = 1'b1;
    w_ptw_addr = 32'h1000_0000;
    w_cpu_req  = 1'b1;
    w_cpu_addr = 32'h2000_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3_addr%0d", i), w_mem_addr,
          exp_cpu[i] ? 32'h2000_0000 : 32'h1000_0000);
      w_mem_resp = 1'b1;
      step();
      w_mem_resp = 1'b0;
      chk($sformatf("t3_presp%0d", i), w_ptw_resp, !exp_cpu[i]);
      chk($sformatf("t3_cresp%0d", i), w_cpu_resp, exp_cpu[i]);
      if (i == 3) begin
        w_ptw_req = 1'b0;
        w_cpu_req = 1'b0;
      end
      step();
    end
    step();
    chk("t3_idle", w_mem_req, 0);

    // cpu arrives while ptw is in flight
    w_ptw_req  = 1'b1;
    w_ptw_addr = 32'h8000_2000;
    step();
    w_cpu_req  = 1'b1;
    w_cpu_addr = 32'h8000_3000;
    step();
    chk("t4_addr_hold", w_mem_addr, 32'h8000_2000);
    w_mem_resp = 1'b1;
    step();
    w_mem_resp = 1'b0;
    chk("t4_presp", w_ptw_resp, 1);
    chk("t4_cresp0", w_cpu_resp, 0);
    chk("t4_addr_resp", w_mem_addr, 32'h8000_2000);
    w_ptw_req = 1'b0;
    step();
    chk("t4_idle", w_mem_req, 0);
    step();
    chk("t4_cpu_req", w_mem_req, 1);
    chk("t4_cpu_addr", w_mem_addr, 32'h8000_3000);
    w_mem_resp  = 1'b1;
    w_mem_rdata = 32'h1111_2222;
    step();
    w_mem_resp  = 1'b0;
    w_mem_rdata = '0;
    chk("t4_cresp", w_cpu_resp, 1);
    chk("t4_rdata", w_rdata, 32'h1111_2222);
    w_cpu_req = 1'b0;
    step();

    // spurious memory response while idle
    w_mem_resp  = 1'b1;
    w_mem_rdata = 32'hFFFF_FFFF;
    step();
    w_mem_resp  = 1'b0;
    chk("t6_presp", w_ptw_resp, 0);
    chk("t6_cresp", w_cpu_resp, 0);
    chk("t6_rdata", w_rdata, 32'h1111_2222);
    chk("t6_req", w_mem_req, 0);
    step();
    chk("t6_presp2", w_ptw_resp, 0);
    chk("t6_cresp2", w_cpu_resp, 0);

    // async reset during ISSUE
    w_ptw_req  = 1'b1;
    w_ptw_addr = 32'h8000_4000;
    step();
    chk("t5_issue", w_mem_req, 1);
    #2;
    RST_X     = 1'b0;
    w_ptw_req = 1'b0;
    #1;
    chk("t5_req_drop", w_mem_req, 0);
    chk("t5_addr_drop", w_mem_addr, 0);
    chk("t5_rdata_drop", w_rdata, 0);
    step();
    RST_X       = 1'b1;
    w_mem_resp  = 1'b1;
    w_mem_rdata = 32'hCAFE_0000;
    step();
    w_mem_resp = 1'b0;
    chk("t5_presp", w_ptw_resp, 0);
    chk("t5_cresp", w_cpu_resp, 0);
    chk("t5_req", w_mem_req, 0);
    step();
    chk("t5_presp2", w_ptw_resp, 0);
    chk("t5_cresp2", w_cpu_resp, 0);
    chk("t5_rdata", w_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
